// File: rtl/discrete_filter_scheduler.sv
// Shared high-pass datapath, time-multiplexed over NUM_CHANNELS audio lanes.
// Each tick publishes the previous pass's results and starts a new pass.
module discrete_filter_scheduler #(
  parameter int CLOCK_RATE    = 50000000,
  parameter int SAMPLE_RATE   = 48000,
  parameter int NUM_CHANNELS  = 4,
  parameter int ALPHA_DEFAULT = 65527
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        audio_clk_en,
  input  logic [16*NUM_CHANNELS-1:0]  in,
  input  logic                        cfg_we,
  input  logic [3:0]                  cfg_addr,
  input  logic [15:0]                 cfg_alpha,
  output logic [16*NUM_CHANNELS-1:0]  out,
  output logic                        busy,
  output logic                        overrun,
  output logic [1:0]                  state_dbg
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
    $error("NUM_CHANNELS must be in 1..16");
  end
  if (CLOCK_RATE / SAMPLE_RATE <= 3 * NUM_CHANNELS + 1) begin : g_bad_rate
    $error("not enough system clocks per sample for a full pass");
  end

  typedef enum logic [1:0] {IDLE, LOAD, MUL, WRITE} state_t;

  state_t                 state;
  logic [CH_W-1:0]        ch;
  logic signed [15:0]     x_prev [NUM_CHANNELS];
  logic signed [15:0]     y_prev [NUM_CHANNELS];
  logic signed [15:0]     snap   [NUM_CHANNELS];
  logic signed [15:0]     result [NUM_CHANNELS];
  logic [15:0]            alpha  [NUM_CHANNELS];
  logic signed [17:0]     sum;
  logic [15:0]            a;
  logic signed [34:0]     prod;
  logic signed [18:0]     shifted;
  logic signed [15:0]     sat;

  assign state_dbg = state;

  // Q0.16 rescale with clamping so large steps pin at full scale instead of wrapping.
  always_comb begin
    shifted = prod[34:16];
    if (shifted > 19'sd32767)
      sat = 16'sh7fff;
    else if (shifted < -19'sd32768)
      sat = 16'sh8000;
    else
      sat = shifted[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ch      <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      out     <= '0;
      sum     <= '0;
      a       <= '0;
      prod    <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        x_prev[k] <= '0;
        y_prev[k] <= '0;
        snap[k]   <= '0;
        result[k] <= '0;
        alpha[k]  <= 16'(ALPHA_DEFAULT);
      end
    end else begin
      if (cfg_we && int'(cfg_addr) < NUM_CHANNELS)
        alpha[cfg_addr[CH_W-1:0]] <= cfg_alpha;

      // A tick always wins: it publishes, re-snapshots and restarts the pass.
      if (audio_clk_en) begin
        if (state != IDLE)
          overrun <= 1'b1;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          out[16*k +: 16] <= result[k];
          snap[k]         <= in[16*k +: 16];
        end
        ch    <= '0;
        busy  <= 1'b1;
        state <= LOAD;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            sum   <= 18'(y_prev[ch]) + 18'(snap[ch]) - 18'(x_prev[ch]);
            a     <= alpha[ch];
            state <= MUL;
          end
          MUL: begin
            prod  <= 35'(sum) * 35'($signed({1'b0, a}));
            state <= WRITE;
          end
          WRITE: begin
            result[ch] <= sat;
            y_prev[ch] <= sat;
            x_prev[ch] <= snap[ch];
            if (ch == LAST_CH) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              ch    <= ch + 1'b1;
              state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_discrete_filter_scheduler.sv
// Bench for discrete_filter_scheduler: directed cases pinned to literals, then
// random ticks/overruns/config writes checked every cycle against a pass-level model.
module tb_discrete_filter_scheduler;

  localparam int N = 4;
  localparam int W = 16 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n      = 1'b0;
  logic          audio_clk_en = 1'b0;
  logic [W-1:0]  din          = '0;
  logic          cfg_we       = 1'b0;
  logic [3:0]    cfg_addr     = '0;
  logic [15:0]   cfg_alpha    = '0;
  logic [W-1:0]  dout;
  logic          busy;
  logic          overrun;
  logic [1:0]    state_dbg;

  discrete_filter_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_clk_en (audio_clk_en),
    .in           (din),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_alpha    (cfg_alpha),
    .out          (dout),
    .busy         (busy),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // ---------------- behavioural model ----------------
  // Tracks cycles since the last tick; channel k reads its alpha 3k+1 cycles
  // after the tick and has its result written 3k+3 cycles after it.
  int m_x [N], m_y [N], m_res [N], m_alpha [N], m_snap [N], m_a [N], m_out [N];
  bit m_busy, m_ovr;
  int cyc = -1;

  function automatic int filt(int y, int x, int xp, int a);
    longint s, p, r;
    s = longint'(y) + longint'(x) - longint'(xp);
    p = s * longint'(a);
    r = p >>> 16;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        m_x[k] = 0; m_y[k] = 0; m_res[k] = 0; m_snap[k] = 0; m_out[k] = 0;
        m_alpha[k] = 65527; m_a[k] = 0;
      end
      m_busy = 0; m_ovr = 0; cyc = -1;
    end else begin
      if (audio_clk_en) begin
        if (cyc >= 0) m_ovr = 1;
        for (int k = 0; k < N; k++) begin
          m_out[k]  = m_res[k];
          m_snap[k] = int'($signed(din[16*k +: 16]));
        end
        cyc = 0;
        m_busy = 1;
      end else if (cyc >= 0) begin
        int k;
        cyc++;
        k = (cyc - 1) / 3;
        if ((cyc - 1) % 3 == 0) m_a[k] = m_alpha[k];
        if ((cyc - 1) % 3 == 2) begin
          m_res[k] = filt(m_y[k], m_snap[k], m_x[k], m_a[k]);
          m_y[k]   = m_res[k];
          m_x[k]   = m_snap[k];
          if (k == N - 1) begin m_busy = 0; cyc = -1; end
        end
      end
      if (cfg_we && int'(cfg_addr) < N) m_alpha[cfg_addr] = int'(cfg_alpha);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_lane(input string name, input int k, input int exp);
    logic [15:0] e;
    logic [15:0] m;
    e = 16'(exp);
    m = 16'(m_out[k]);
    chk({name, "_model"}, W'(m), W'(e));
    chk(name, W'(dout[16*k +: 16]), W'(e));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic [W-1:0] exp_out;
      for (int k = 0; k < N; k++) exp_out[16*k +: 16] = 16'(m_out[k]);
      chk("out", dout, exp_out);
      chk("busy", W'(busy), W'(m_busy));
      chk("overrun", W'(overrun), W'(m_ovr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic en, input logic [W-1:0] v, input logic we,
                       input logic [3:0] addr, input logic [15:0] al);
    audio_clk_en = en; din = v; cfg_we = we; cfg_addr = addr; cfg_alpha = al;
    @(negedge clk);
    audio_clk_en = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, din, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic tick(input logic [W-1:0] v);
    cycle(1'b1, v, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic cfg(input logic [3:0] addr, input logic [15:0] al);
    cycle(1'b0, din, 1'b1, addr, al);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) cycle(1'b1, {N{16'h1234}}, 1'b0, 4'd0, 16'd0);
    reset_n = 1'b1;
  endtask

  function automatic logic [W-1:0] all_lanes(input int v);
    return {N{16'(v)}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_out", dout, '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_overrun", W'(overrun), '0);
    chk_on = 1'b1;

    // Step response on channel 0
    cfg(4'd0, 16'd32768);
    tick(W'(1000));
    chk_lane("step_first_tick", 0, 0);
    idle(11);
    chk("busy_before_end", W'(busy), W'(1));
    idle(1);
    chk("busy_after_12", W'(busy), '0);
    idle(8);
    tick(W'(1000)); chk_lane("step_t2", 0, 500); idle(20);
    tick(W'(1000)); chk_lane("step_t3", 0, 250); idle(20);
    tick(W'(1000)); chk_lane("step_t4", 0, 125); idle(20);

    // Channel independence
    do_reset();
    cfg(4'd0, 16'd32768); cfg(4'd1, 16'd16384); cfg(4'd2, 16'd0); cfg(4'd3, 16'd65535);
    tick(all_lanes(1000)); idle(20);
    tick(all_lanes(0));
    chk_lane("indep_ch0", 0, 500);
    chk_lane("indep_ch1", 1, 250);
    chk_lane("indep_ch2", 2, 0);
    chk_lane("indep_ch3", 3, 999);
    idle(20);

    // Saturation: x_prev=-32768 with y_prev=0, then a full-scale positive step
    do_reset();
    cfg(4'd0, 16'd0);
    tick(W'(16'h8000)); idle(20);
    cfg(4'd0, 16'd65535);
    tick(W'(16'h7fff)); idle(20);
    tick(W'(16'h7fff));
    chk_lane("saturate_ch0", 0, 32767);
    idle(20);

    // Overrun: second tick 5 clocks after the first
    do_reset();
    for (int k = 0; k < N; k++) cfg(4'(k), 16'd32768);
    tick(all_lanes(1000)); idle(20);
    tick(all_lanes(2000));
    idle(4);
    chk("no_overrun_yet", W'(overrun), '0);
    tick(all_lanes(2000));
    chk("overrun_set", W'(overrun), W'(1));
    chk_lane("ovr_ch0_new", 0, 750);
    chk_lane("ovr_ch1_prior", 1, 500);
    chk_lane("ovr_ch3_prior", 3, 500);
    idle(11);
    chk("ovr_busy_11", W'(busy), W'(1));
    idle(1);
    chk("ovr_busy_12", W'(busy), '0);
    idle(8);
    tick(all_lanes(2000));
    chk_lane("after_ovr_ch0", 0, 375);
    chk_lane("after_ovr_ch1", 1, 750);
    idle(20);

    // Config race on ch1 LOAD cycle and an out-of-range address
    do_reset();
    for (int k = 0; k < N; k++) cfg(4'(k), 16'd32768);
    tick(all_lanes(1000)); idle(20);
    tick(all_lanes(1000));
    idle(3);
    cfg(4'd1, 16'd0);
    idle(10);
    cfg(4'd9, 16'd0);
    idle(10);
    tick(all_lanes(1000));
    chk_lane("race_old_alpha", 1, 250);
    chk_lane("race_ch0", 0, 250);
    idle(20);
    tick(all_lanes(1000));
    chk_lane("race_new_alpha", 1, 0);
    chk_lane("addr9_ignored", 0, 125);
    idle(20);

    // Random phase: ticks, overruns (avoiding WRITE-cycle collisions), config writes
    do_reset();
    for (int k = 0; k < N; k++) cfg(4'(k), 16'($urandom_range(0, 65535)));
    for (int it = 0; it < 80; it++) begin
      int g;
      logic [W-1:0] v;
      for (int k = 0; k < N; k++) v[16*k +: 16] = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) begin
        cycle(1'b1, v, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
      end else begin
        tick(v);
      end
      if ($urandom_range(0, 4) == 0) begin
        do g = $urandom_range(1, 11); while (g % 3 == 0);
      end else begin
        g = $urandom_range(13, 25);
      end
      for (int i = 0; i < g - 1; i++) begin
        if ($urandom_range(0, 5) == 0)
          cfg(4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
        else
          idle(1);
      end
    end
    idle(20);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
